cell_link_loopback_tester: RTL and testbench

Sequencer that runs a self-test on one Cell Controller ring link (CCW or CW) through the simulation/diagnostic loopback path. It closes the selected loop, transmits one packet of known pattern words on that ring's AXI-Stream TX, and checks the words returning on the matching RX. It then reopens the loop and reports pass/fail, error count and timeout. It sits beside the ring AXI-Stream loopback and drives its close-loop controls.

---
 rtl/cell_loopback_pkg.sv | 43 ++++
 rtl/loopback_pattern_gen.sv | 30 +++
 rtl/cell_link_loopback_tester.sv | 206 ++++++++++++++++++++
 tb/tb_cell_link_loopback_tester.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cell_loopback_pkg.sv
// ============================================================================
// cell_loopback_pkg : shared types and pattern math for the ring loopback tester
// Rev 1.0 -- CELL_LOOPBACK_PRBS_EN selects the LFSR pattern instead of +1
// ============================================================================
`default_nettype none

package cell_loopback_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_SEND    = 3'd2,
    ST_WAIT_RX = 3'd3,
    ST_OPEN    = 3'd4
  } state_t;

  // x^32 + x^22 + x^2 + x + 1, left-shifting Galois form (x^32 term implicit)
  localparam logic [31:0] LFSR_POLY = 32'h0040_0007;

  function automatic logic [31:0] lfsr_step(input logic [31:0] cur);
    lfsr_step = {cur[30:0], 1'b0} ^ (cur[31] ? LFSR_POLY : 32'h0);
  endfunction

  function automatic logic [31:0] pattern_next(input logic [31:0] cur);
`ifdef CELL_LOOPBACK_PRBS_EN
    pattern_next = lfsr_step(cur);
`else
    pattern_next = cur + 32'd1;
`endif
  endfunction

  // The LFSR locks up at zero, so a zero seed is promoted to 1
  function automatic logic [31:0] pattern_seed(input logic [31:0] s);
`ifdef CELL_LOOPBACK_PRBS_EN
    pattern_seed = (s == 32'h0) ? 32'h1 : s;
`else
    pattern_seed = s;
`endif
  endfunction

endpackage

`default_nettype wire

// File: rtl/loopback_pattern_gen.sv
// ============================================================================
// loopback_pattern_gen : holds the current pattern word; load seed or advance
// Rev 1.0
// ============================================================================
`default_nettype none

module loopback_pattern_gen
  import cell_loopback_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        advance,
  output logic [31:0] word
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word <= 32'h0;
    end else if (load) begin
      word <= pattern_seed(seed);
    end else if (advance) begin
      word <= pattern_next(word);
    end
  end

endmodule

`default_nettype wire

// File: rtl/cell_link_loopback_tester.sv
// ============================================================================
// cell_link_loopback_tester : closes one ring loop, sends a pattern packet and
// checks the returning words. Rev 1.0 -- option macro: CELL_LOOPBACK_PRBS_EN
// ============================================================================
`default_nettype none

module cell_link_loopback_tester
  import cell_loopback_pkg::*;
#(
  parameter int LEN_WIDTH      = 8,
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 sysClk,
  input  logic                 sysReset_n,
  input  logic                 start,
  input  logic                 ring_select,
  input  logic [LEN_WIDTH-1:0] packet_len,
  input  logic [31:0]          seed,
  output logic                 close_loop_ccw,
  output logic                 close_loop_cw,
  output logic [31:0]          ccw_tx_tdata,
  output logic                 ccw_tx_tlast,
  output logic                 ccw_tx_tvalid,
  output logic [31:0]          cw_tx_tdata,
  output logic                 cw_tx_tlast,
  output logic                 cw_tx_tvalid,
  input  logic [31:0]          ccw_rx_tdata,
  input  logic                 ccw_rx_tlast,
  input  logic                 ccw_rx_tvalid,
  input  logic [31:0]          cw_rx_tdata,
  input  logic                 cw_rx_tlast,
  input  logic                 cw_rx_tvalid,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 timeout,
  output logic [15:0]          error_count,
  output logic                 cfg_error
);

  localparam int CNT_MAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0]     SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]     TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]     CNT_ONE      = CNT_W'(1);
  localparam logic [LEN_WIDTH-1:0] LEN_ONE      = LEN_WIDTH'(1);
  localparam logic [LEN_WIDTH:0]   IDX_ONE      = (LEN_WIDTH + 1)'(1);

  state_t               state, state_nx;
  logic                 ring, ring_nx;
  logic [LEN_WIDTH-1:0] len;
  logic [LEN_WIDTH:0]   len_ext, tx_idx;
  logic [LEN_WIDTH-1:0] rx_idx;
  logic                 rx_done, rx_done_nx;
  logic [CNT_W-1:0]     cnt;
  logic [31:0]          tx_word, exp_word, rx_data;
  logic                 accept, emit, tx_is_last, close_nx, timeout_hit;
  logic                 rx_valid, rx_last, beat, rx_got_last;
  logic [1:0]           err_inc;
  logic [16:0]          err_sum;

  assign accept  = start && (state == ST_IDLE) && (packet_len != '0);
  assign ring_nx = accept ? ring_select : ring;
  assign len_ext = {1'b0, len};

  assign rx_valid = ring ? cw_rx_tvalid : ccw_rx_tvalid;
  assign rx_last  = ring ? cw_rx_tlast  : ccw_rx_tlast;
  assign rx_data  = ring ? cw_rx_tdata  : ccw_rx_tdata;

  // RX is checked in both SEND and WAIT_RX so a zero-latency loop is caught
  assign beat        = rx_valid && ((state == ST_SEND) || (state == ST_WAIT_RX));
  assign rx_got_last = beat && !rx_done && rx_last;
  assign rx_done_nx  = rx_done || rx_got_last;

  assign emit = ((state == ST_SETTLE) && (cnt == SETTLE_LAST)) ||
                ((state == ST_SEND) && (tx_idx != len_ext));
  assign tx_is_last = (tx_idx == (len_ext - IDX_ONE));

  always_comb begin
    err_inc = 2'd0;
    if (beat) begin
      if (rx_done) begin
        err_inc = 2'd1;
      end else begin
        err_inc = 2'(rx_data != exp_word) + 2'(rx_last != (rx_idx == (len - LEN_ONE)));
      end
    end
  end

  assign err_sum = {1'b0, error_count} + 17'(err_inc);

  always_comb begin
    state_nx    = state;
    timeout_hit = 1'b0;
    case (state)
      ST_IDLE:    if (accept) state_nx = ST_SETTLE;
      ST_SETTLE:  if (cnt == SETTLE_LAST) state_nx = ST_SEND;
      // Skip WAIT_RX when tlast already came back so done lands two cycles after the last word
      ST_SEND:    if (tx_idx == len_ext) state_nx = rx_done_nx ? ST_OPEN : ST_WAIT_RX;
      ST_WAIT_RX: begin
        if (rx_done_nx) begin
          state_nx = ST_OPEN;
        end else if (cnt == TIMEOUT_LAST) begin
          state_nx    = ST_OPEN;
          timeout_hit = 1'b1;
        end
      end
      ST_OPEN:    state_nx = ST_IDLE;
      default:    state_nx = ST_IDLE;
    endcase
  end

  assign close_nx = (state_nx == ST_SETTLE) || (state_nx == ST_SEND) || (state_nx == ST_WAIT_RX);

  always_ff @(posedge sysClk or negedge sysReset_n) begin
    if (!sysReset_n) begin
      state   <= ST_IDLE;
      ring    <= 1'b0;
      len     <= '0;
      tx_idx  <= '0;
      rx_idx  <= '0;
      rx_done <= 1'b0;
      cnt     <= '0;
    end else begin
      state <= state_nx;
      if (state_nx != state) begin
        cnt <= '0;
      end else if ((state == ST_SETTLE) || (state == ST_WAIT_RX)) begin
        cnt <= cnt + CNT_ONE;
      end
      if (accept) begin
        ring    <= ring_select;
        len     <= packet_len;
        tx_idx  <= '0;
        rx_idx  <= '0;
        rx_done <= 1'b0;
      end else begin
        if (emit) tx_idx <= tx_idx + IDX_ONE;
        if (beat && !rx_done) rx_idx <= rx_idx + LEN_ONE;
        rx_done <= rx_done_nx;
      end
    end
  end

  always_ff @(posedge sysClk or negedge sysReset_n) begin
    if (!sysReset_n) begin
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      timeout        <= 1'b0;
      error_count    <= 16'h0;
      cfg_error      <= 1'b0;
      close_loop_ccw <= 1'b0;
      close_loop_cw  <= 1'b0;
      ccw_tx_tdata   <= 32'h0;
      ccw_tx_tlast   <= 1'b0;
      ccw_tx_tvalid  <= 1'b0;
      cw_tx_tdata    <= 32'h0;
      cw_tx_tlast    <= 1'b0;
      cw_tx_tvalid   <= 1'b0;
    end else begin
      busy           <= (state_nx != ST_IDLE);
      done           <= (state == ST_OPEN);
      cfg_error      <= start && (state == ST_IDLE) && (packet_len == '0);
      close_loop_ccw <= close_nx && !ring_nx;
      close_loop_cw  <= close_nx && ring_nx;
      ccw_tx_tvalid  <= emit && !ring;
      ccw_tx_tlast   <= emit && !ring && tx_is_last;
      ccw_tx_tdata   <= (emit && !ring) ? tx_word : 32'h0;
      cw_tx_tvalid   <= emit && ring;
      cw_tx_tlast    <= emit && ring && tx_is_last;
      cw_tx_tdata    <= (emit && ring) ? tx_word : 32'h0;
      if (accept) begin
        error_count <= 16'h0;
        pass        <= 1'b0;
        timeout     <= 1'b0;
      end else begin
        if (beat) error_count <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
        if (timeout_hit) timeout <= 1'b1;
        if (state == ST_OPEN) pass <= (error_count == 16'h0) && !timeout;
      end
    end
  end

  loopback_pattern_gen u_tx_gen (
    .clk     (sysClk),
    .rst_n   (sysReset_n),
    .load    (accept),
    .seed    (seed),
    .advance (emit),
    .word    (tx_word)
  );

  loopback_pattern_gen u_rx_gen (
    .clk     (sysClk),
    .rst_n   (sysReset_n),
    .load    (accept),
    .seed    (seed),
    .advance (beat && !rx_done),
    .word    (exp_word)
  );

endmodule

`default_nettype wire

// File: tb/tb_cell_link_loopback_tester.sv
// ============================================================================
// tb_cell_link_loopback_tester : directed scenarios against the loopback tester
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_cell_link_loopback_tester;

  localparam int S = 4;
  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, ring_select;
  logic [7:0]  packet_len;
  logic [31:0] seed;
  logic        close_loop_ccw, close_loop_cw;
  logic [31:0] ccw_tx_tdata, cw_tx_tdata, ccw_rx_tdata, cw_rx_tdata;
  logic        ccw_tx_tlast, ccw_tx_tvalid, cw_tx_tlast, cw_tx_tvalid;
  logic        ccw_rx_tlast, ccw_rx_tvalid, cw_rx_tlast, cw_rx_tvalid;
  logic        busy, done, pass, timeout, cfg_error;
  logic [15:0] error_count;

  int errors = 0;
  int checks = 0;
  int mode;
  logic cur_ring;

  int done_k, first_k, last_idx, ntx, leak, other;
  logic busy0, close0;
  logic [31:0] words [16];

  // mode 0: zero-latency loop, 1: 5-stage CW delay with word 1 corrupted, 2: disconnected
  logic [33:0] dl [5];
  int dl_idx;

  always #5 clk = ~clk;

  cell_link_loopback_tester #(.LEN_WIDTH(8), .SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
    .sysClk(clk), .sysReset_n(rst_n), .start(start), .ring_select(ring_select),
    .packet_len(packet_len), .seed(seed),
    .close_loop_ccw(close_loop_ccw), .close_loop_cw(close_loop_cw),
    .ccw_tx_tdata(ccw_tx_tdata), .ccw_tx_tlast(ccw_tx_tlast), .ccw_tx_tvalid(ccw_tx_tvalid),
    .cw_tx_tdata(cw_tx_tdata), .cw_tx_tlast(cw_tx_tlast), .cw_tx_tvalid(cw_tx_tvalid),
    .ccw_rx_tdata(ccw_rx_tdata), .ccw_rx_tlast(ccw_rx_tlast), .ccw_rx_tvalid(ccw_rx_tvalid),
    .cw_rx_tdata(cw_rx_tdata), .cw_rx_tlast(cw_rx_tlast), .cw_rx_tvalid(cw_rx_tvalid),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .error_count(error_count), .cfg_error(cfg_error)
  );

  always @(posedge clk) begin
    dl[0] <= {cw_tx_tvalid, cw_tx_tlast,
              cw_tx_tdata ^ ((cw_tx_tvalid && dl_idx == 1) ? 32'h0000_0100 : 32'h0)};
    for (int i = 1; i < 5; i++) dl[i] <= dl[i-1];
    if (!busy) dl_idx <= 0;
    else if (cw_tx_tvalid) dl_idx <= dl_idx + 1;
  end

  assign ccw_rx_tvalid = (mode == 0) ? ccw_tx_tvalid : 1'b0;
  assign ccw_rx_tlast  = (mode == 0) ? ccw_tx_tlast  : 1'b0;
  assign ccw_rx_tdata  = (mode == 0) ? ccw_tx_tdata  : 32'h0;
  assign cw_rx_tvalid  = (mode == 0) ? cw_tx_tvalid : (mode == 1) ? dl[4][33]   : 1'b0;
  assign cw_rx_tlast   = (mode == 0) ? cw_tx_tlast  : (mode == 1) ? dl[4][32]   : 1'b0;
  assign cw_rx_tdata   = (mode == 0) ? cw_tx_tdata  : (mode == 1) ? dl[4][31:0] : 32'h0;

  function automatic logic [31:0] model_next(input logic [31:0] w);
`ifdef CELL_LOOPBACK_PRBS_EN
    model_next = {w[30:0], 1'b0} ^ (w[31] ? 32'h0040_0007 : 32'h0);
`else
    model_next = w + 32'd1;
`endif
  endfunction

  task automatic launch(input logic r, input logic [7:0] l, input logic [31:0] s);
    @(negedge clk);
    cur_ring = r; ring_select = r; packet_len = l; seed = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // k counts negedges after the accepting edge; k=0 is the first cycle with busy high
  task automatic watch(input int max_cyc);
    done_k = -1; first_k = -1; last_idx = -1; ntx = 0; leak = 0; other = 0;
    busy0 = busy;
    close0 = cur_ring ? close_loop_cw : close_loop_ccw;
    for (int k = 0; k < max_cyc; k++) begin
      if (k > 0) @(negedge clk);
      if ((close_loop_ccw || close_loop_cw) && !busy) leak = 1;
      if (cur_ring ? (ccw_tx_tvalid || ccw_tx_tlast || ccw_tx_tdata != 0 || close_loop_ccw)
                   : (cw_tx_tvalid || cw_tx_tlast || cw_tx_tdata != 0 || close_loop_cw)) other = 1;
      if (cur_ring ? cw_tx_tvalid : ccw_tx_tvalid) begin
        if (ntx == 0) first_k = k;
        if (ntx < 16) words[ntx] = cur_ring ? cw_tx_tdata : ccw_tx_tdata;
        if (cur_ring ? cw_tx_tlast : ccw_tx_tlast) last_idx = ntx;
        ntx++;
      end
      if (done) begin
        done_k = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if ({busy, done, pass, timeout, cfg_error} !== 5'b0) begin errors++;
      $display("FAIL reset_status: got %b expected 00000", {busy, done, pass, timeout, cfg_error}); end
    checks++; if (error_count !== 16'h0) begin errors++;
      $display("FAIL reset_error_count: got %0h expected 0", error_count); end
    checks++; if ({close_loop_ccw, close_loop_cw, ccw_tx_tvalid, cw_tx_tvalid, ccw_tx_tlast, cw_tx_tlast} !== 6'b0
                  || ccw_tx_tdata !== 32'h0 || cw_tx_tdata !== 32'h0) begin errors++;
      $display("FAIL reset_link: got close=%b%b tvalid=%b%b expected all 0",
               close_loop_ccw, close_loop_cw, ccw_tx_tvalid, cw_tx_tvalid); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_zero_latency_ccw();
    logic [31:0] w;
    mode = 0;
    launch(1'b0, 8'd4, 32'h10);
    watch(40);
    checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL zl_busy_start: got %b expected 1", busy0); end
    checks++; if (close0 !== 1'b1) begin errors++; $display("FAIL zl_close_start: got %b expected 1", close0); end
    checks++; if (first_k != S) begin errors++; $display("FAIL zl_first_word_cycle: got %0d expected %0d", first_k, S); end
    checks++; if (ntx != 4) begin errors++; $display("FAIL zl_word_count: got %0d expected 4", ntx); end
    w = 32'h10;
    for (int j = 0; j < 4; j++) begin
      checks++; if (words[j] !== w) begin errors++;
        $display("FAIL zl_word%0d: got %0h expected %0h", j, words[j], w); end
      w = model_next(w);
    end
    checks++; if (last_idx != 3) begin errors++; $display("FAIL zl_tlast_index: got %0d expected 3", last_idx); end
    checks++; if (done_k != S + 4 + 1) begin errors++; $display("FAIL zl_done_cycle: got %0d expected %0d", done_k, S + 5); end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL zl_pass: got %b expected 1", pass); end
    checks++; if (error_count !== 16'h0) begin errors++; $display("FAIL zl_error_count: got %0h expected 0", error_count); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL zl_timeout: got %b expected 0", timeout); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zl_busy_at_done: got %b expected 0", busy); end
    checks++; if (other != 0) begin errors++; $display("FAIL zl_cw_quiet: got %0d expected 0", other); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL zl_done_pulse_width: got %b expected 0", done); end
  endtask

  task automatic test_delayed_cw_error();
    mode = 1;
    launch(1'b1, 8'd3, 32'hA0);
    watch(60);
    checks++; if (close0 !== 1'b1) begin errors++; $display("FAIL dly_close_cw: got %b expected 1", close0); end
    checks++; if (error_count !== 16'd1) begin errors++; $display("FAIL dly_error_count: got %0d expected 1", error_count); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL dly_pass: got %b expected 0", pass); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL dly_timeout: got %b expected 0", timeout); end
    checks++; if (leak != 0) begin errors++; $display("FAIL dly_close_outside_busy: got %0d expected 0", leak); end
    checks++; if (other != 0) begin errors++; $display("FAIL dly_ccw_quiet: got %0d expected 0", other); end
    checks++; if (done_k != 13) begin errors++; $display("FAIL dly_done_cycle: got %0d expected 13", done_k); end
  endtask

  task automatic test_cfg_error();
    @(negedge clk);
    packet_len = 8'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if (cfg_error !== 1'b1) begin errors++; $display("FAIL cfg_pulse: got %b expected 1", cfg_error); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cfg_busy: got %b expected 0", busy); end
    checks++; if (error_count !== 16'd1) begin errors++; $display("FAIL cfg_error_count_kept: got %0d expected 1", error_count); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL cfg_pass_kept: got %b expected 0", pass); end
    @(negedge clk);
    checks++; if (cfg_error !== 1'b0) begin errors++; $display("FAIL cfg_pulse_width: got %b expected 0", cfg_error); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cfg_busy_after: got %b expected 0", busy); end
  endtask

  task automatic test_timeout();
    mode = 2;
    launch(1'b0, 8'd2, 32'h5);
    watch(80);
    checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL to_timeout: got %b expected 1", timeout); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL to_pass: got %b expected 0", pass); end
    checks++; if (error_count !== 16'h0) begin errors++; $display("FAIL to_error_count: got %0d expected 0", error_count); end
    checks++; if (done_k != S + 1 + T + 2) begin errors++;
      $display("FAIL to_done_cycle: got %0d expected %0d", done_k, S + 1 + T + 2); end
  endtask

  task automatic test_reset_mid_send();
    logic [31:0] w;
    mode = 0;
    launch(1'b0, 8'd8, 32'h100);
    repeat (S + 2) @(negedge clk);
    checks++; if (ccw_tx_tvalid !== 1'b1) begin errors++; $display("FAIL rst_in_send: got %b expected 1", ccw_tx_tvalid); end
    rst_n = 1'b0;
    #1;
    checks++; if (close_loop_ccw !== 1'b0) begin errors++; $display("FAIL rst_close_drop: got %b expected 0", close_loop_ccw); end
    checks++; if (ccw_tx_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid_drop: got %b expected 0", ccw_tx_tvalid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy_drop: got %b expected 0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    launch(1'b0, 8'd5, 32'hFFFF_FFFE);
    watch(40);
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL rst_rerun_pass: got %b expected 1", pass); end
    checks++; if (error_count !== 16'h0) begin errors++; $display("FAIL rst_rerun_errors: got %0d expected 0", error_count); end
    checks++; if (done_k != S + 5 + 1) begin errors++; $display("FAIL rst_rerun_done_cycle: got %0d expected %0d", done_k, S + 6); end
    w = 32'hFFFF_FFFE;
    for (int j = 0; j < 5; j++) begin
      checks++; if (words[j] !== w) begin errors++;
        $display("FAIL rst_rerun_word%0d: got %0h expected %0h", j, words[j], w); end
      w = model_next(w);
    end
  endtask

`ifdef CELL_LOOPBACK_PRBS_EN
  task automatic test_prbs_seed0();
    mode = 0;
    launch(1'b0, 8'd3, 32'h0);
    watch(40);
    checks++; if (words[0] !== 32'h1) begin errors++; $display("FAIL prbs_first_word: got %0h expected 1", words[0]); end
    checks++; if (words[1] !== 32'h2) begin errors++; $display("FAIL prbs_second_word: got %0h expected 2", words[1]); end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL prbs_pass: got %b expected 1", pass); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; ring_select = 1'b0; packet_len = 8'd0; seed = 32'h0;
    mode = 0; cur_ring = 1'b0; dl_idx = 0;
    test_reset();
    test_zero_latency_ccw();
    test_delayed_cw_error();
    test_cfg_error();
    test_timeout();
    test_reset_mid_send();
`ifdef CELL_LOOPBACK_PRBS_EN
    test_prbs_seed0();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
